// File: rtl/ita_regfile_read_sequencer_pkg.sv
// rtl/ita_regfile_read_sequencer_pkg.sv - shared types for the regfile read sequencer
//
// Purpose : FSM state encoding and burst request record used by the read
//           sequencer and its address generator.
// Ports   : none (package).

package ita_regfile_read_sequencer_pkg;

  localparam int unsigned RF_RD_ADDR_WIDTH = 5;
  localparam int unsigned RF_RD_DATA_WIDTH = 32;
  localparam int unsigned RF_RD_LEN_WIDTH  = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rf_rd_state_e;

  // Burst request as presented by the controller (default widths).
  typedef struct packed {
    logic [RF_RD_ADDR_WIDTH-1:0] base;
    logic [RF_RD_ADDR_WIDTH-1:0] stride;
    logic [RF_RD_LEN_WIDTH-1:0]  len;
  } rf_rd_req_t;

endpackage

// File: rtl/ita_regfile_read_sequencer_addr_gen.sv
// rtl/ita_regfile_read_sequencer_addr_gen.sv - burst address and beat counter
//
// Purpose : Holds the current read address, the per-beat stride and the
//           number of beats still to issue after the current one.
// Ports   : clk, rst_n   clock, async active-low reset
//           load_i       capture base/stride/len (wins over step_i)
//           base_i       first word address
//           stride_i     unsigned address increment per beat
//           len_i        beats minus one
//           step_i       current beat issued: advance address, count down
//           addr_o       current read address
//           last_o       current beat is the final one of the burst

module ita_regfile_read_sequencer_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  step_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [LEN_WIDTH-1:0]  rem_q,    rem_d;

  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    rem_d    = rem_q;
    if (load_i) begin
      addr_d   = base_i;
      stride_d = stride_i;
      rem_d    = len_i;
    end else if (step_i) begin
      // Address wraps naturally modulo 2**ADDR_WIDTH.
      addr_d = addr_q + stride_q;
      // Stepping the final beat leaves the count at zero rather than
      // underflowing, so the idle counter reads as a clean zero.
      if (rem_q != '0) begin
        rem_d = rem_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      stride_q <= '0;
      rem_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
      rem_q    <= rem_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (rem_q == '0);

endmodule

// File: rtl/ita_regfile_read_sequencer.sv
// rtl/ita_regfile_read_sequencer.sv - burst read master for one latch regfile read port
//
// Purpose : Accepts a burst request (base, stride, len) and drives one read
//           port of the latch-based register file (registered address,
//           1-cycle latency), returning the words as a valid/ready stream
//           with a last flag. Back-to-back bursts run with no bubble.
// Config  : ITA_RF_RD_HAZARD_EN - when defined, a regfile write to the
//           address about to be read holds the read one cycle so it returns
//           the newly written word. When undefined snoop_* are ignored.
// Ports   : clk, rst_n                       clock, async active-low reset
//           req_valid_i/req_ready_o          burst request handshake
//           req_base_i/req_stride_i/req_len_i burst description (len = beats-1)
//           rf_re_o/rf_raddr_o/rf_rdata_i    regfile read port
//           snoop_we_i/snoop_waddr_i         regfile write port observation
//           rd_valid_o/rd_ready_i            output beat handshake
//           rd_data_o/rd_last_o              output beat data and final flag

module ita_regfile_read_sequencer
  import ita_regfile_read_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_base_i,
  input  logic [ADDR_WIDTH-1:0] req_stride_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  output logic                  rf_re_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  input  logic                  snoop_we_i,
  input  logic [ADDR_WIDTH-1:0] snoop_waddr_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o
);

  rf_rd_state_e state_q, state_d;
  logic         rd_valid_q, rd_valid_d;
  logic         rd_last_q,  rd_last_d;

  logic                  hazard;
  logic                  issue;
  logic                  accept;
  logic                  cur_last;
  logic [ADDR_WIDTH-1:0] cur_addr;

  ita_regfile_read_sequencer_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .base_i   (req_base_i),
    .stride_i (req_stride_i),
    .len_i    (req_len_i),
    .step_i   (issue),
    .addr_o   (cur_addr),
    .last_o   (cur_last)
  );

`ifdef ITA_RF_RD_HAZARD_EN
  // The write lands in the latch during the next cycle's high phase; a read
  // launched now would see its data change mid-cycle, so wait one cycle.
  assign hazard = snoop_we_i && (snoop_waddr_i == cur_addr);
`else
  logic unused_snoop;
  assign unused_snoop = ^{snoop_we_i, snoop_waddr_i};
  assign hazard       = 1'b0;
`endif

  // A beat may launch whenever the output slot is empty or being drained;
  // stalls cost nothing because the regfile holds its address register.
  assign issue       = (state_q == RUN) && (!rd_valid_q || rd_ready_i) && !hazard;
  assign req_ready_o = (state_q == IDLE) || (issue && cur_last);
  assign accept      = req_valid_i && req_ready_o;

  assign rf_re_o    = issue;
  assign rf_raddr_o = cur_addr;
  assign rd_data_o  = rf_rdata_i;
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;

  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;

    if (accept) begin
      state_d = RUN;
    end else if (issue && cur_last) begin
      state_d = IDLE;
    end

    if (issue) begin
      rd_valid_d = 1'b1;
      rd_last_d  = cur_last;
    end else if (rd_valid_q && rd_ready_i) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

endmodule

// File: tb/tb_ita_regfile_read_sequencer.sv
// tb/tb_ita_regfile_read_sequencer.sv - self-checking bench for the regfile read sequencer

module tb_ita_regfile_read_sequencer;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LW = 6;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_base = '0;
  logic [AW-1:0] req_stride = '0;
  logic [LW-1:0] req_len = '0;
  logic          rf_re;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          snoop_we = 1'b0;
  logic [AW-1:0] snoop_waddr = '0;
  logic [DW-1:0] snoop_wdata = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  logic [DW-1:0] rd_data;
  logic          rd_last;

  always #5 clk = ~clk;

  ita_regfile_read_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_base_i    (req_base),
    .req_stride_i  (req_stride),
    .req_len_i     (req_len),
    .rf_re_o       (rf_re),
    .rf_raddr_o    (rf_raddr),
    .rf_rdata_i    (rf_rdata),
    .snoop_we_i    (snoop_we),
    .snoop_waddr_i (snoop_waddr),
    .rd_valid_o    (rd_valid),
    .rd_ready_i    (rd_ready),
    .rd_data_o     (rd_data),
    .rd_last_o     (rd_last)
  );

  // Register file read port: address register loads only when ReadEnable is high.
  logic [DW-1:0] rf_mem [NW];
  logic [AW-1:0] rf_raddr_reg = '0;
  logic          init_mem = 1'b1;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < NW; i++) rf_mem[i] <= 32'hA0 + i;
    end else if (snoop_we) begin
      rf_mem[snoop_waddr] <= snoop_wdata;
    end
    if (rf_re) rf_raddr_reg <= rf_raddr;
  end
  assign rf_rdata = rf_mem[rf_raddr_reg];

  // Reference model: word contents and the expected beat sequence.
  logic [DW-1:0] ref_mem [NW];
  int            exp_addr[$];
  bit            exp_last[$];
  int            beat_cyc[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            accept_cyc = 0;
  int            n_beats = 0;
  bit            acc_seen = 0;
  bit            rand_ready_en = 0;
  bit            was_stall = 0;
  logic [DW-1:0] stall_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: observe at the falling edge, then move to just after the rising edge.
  task automatic tick();
    int a;
    @(negedge clk);
    if (rst_n) begin
      if (rd_valid && !rd_ready) begin
        check_eq("stall_re", {31'd0, rf_re}, 32'd0);
        if (was_stall) check_eq("stall_data", rd_data, stall_data);
        stall_data = rd_data;
        was_stall  = 1;
      end else begin
        was_stall = 0;
      end
      if (rd_valid && rd_ready) begin
        if (exp_addr.size() == 0) begin
          check_eq("unexpected_beat", 32'd1, 32'd0);
        end else begin
          a = exp_addr.pop_front();
          check_eq("beat_data", rd_data, ref_mem[a]);
          check_eq("beat_last", {31'd0, rd_last}, {31'd0, exp_last.pop_front()});
        end
        beat_cyc.push_back(cyc);
        n_beats++;
      end
      if (req_valid && req_ready) begin
        for (int k = 0; k <= int'(req_len); k++) begin
          exp_addr.push_back((int'(req_base) + k * int'(req_stride)) % NW);
          exp_last.push_back(k == int'(req_len));
        end
        accept_cyc = cyc;
        acc_seen   = 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rand_ready_en) rd_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_req(input int base, input int stride, input int len);
    req_base   = AW'(base);
    req_stride = AW'(stride);
    req_len    = LW'(len);
    req_valid  = 1'b1;
    acc_seen   = 0;
    for (int i = 0; i < 200 && !acc_seen; i++) tick();
    if (!acc_seen) check_eq("req_accept_timeout", 32'd1, 32'd0);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 2000; i++) begin
      if (exp_addr.size() == 0 && !rd_valid && req_ready) break;
      tick();
    end
    if (i == 2000) check_eq("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_beats(input int n);
    int i;
    for (i = 0; i < 200 && n_beats < n; i++) tick();
    if (n_beats < n) check_eq("beat_wait_timeout", n_beats, n);
  endtask

  initial begin
    int exp_total;
    int len;
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'hA0 + i;

    // Reset values
    tick();
    tick();
    init_mem = 1'b0;
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_rf_re", {31'd0, rf_re}, 32'd0);
    check_eq("rst_rf_raddr", {27'd0, rf_raddr}, 32'd0);
    check_eq("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("rst_rd_last", {31'd0, rd_last}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: basic burst, latency and throughput
    beat_cyc.delete();
    n_beats = 0;
    send_req(3, 1, 3);
    wait_done();
    check_eq("t1_beats", n_beats, 4);
    if (beat_cyc.size() == 4) begin
      for (int k = 0; k < 4; k++) check_eq("t1_beat_cycle", beat_cyc[k] - accept_cyc, k + 2);
    end

    // 2: address wrap-around
    n_beats = 0;
    send_req(30, 1, 3);
    wait_done();
    check_eq("t2_beats", n_beats, 4);

    // 3: backpressure on beat 2
    n_beats = 0;
    send_req(3, 1, 4);
    wait_beats(2);
    rd_ready = 1'b0;
    #1;
    check_eq("t3_hold_data", rd_data, 32'hA5);
    for (int k = 0; k < 3; k++) tick();
    check_eq("t3_hold_data_end", rd_data, 32'hA5);
    rd_ready = 1'b1;
    wait_done();
    check_eq("t3_beats", n_beats, 5);

    // 4: back-to-back bursts with no bubble
    beat_cyc.delete();
    n_beats = 0;
    send_req(0, 1, 0);
    send_req(8, 1, 1);
    wait_done();
    check_eq("t4_beats", n_beats, 3);
    if (beat_cyc.size() == 3) begin
      check_eq("t4_gap1", beat_cyc[1] - beat_cyc[0], 1);
      check_eq("t4_gap2", beat_cyc[2] - beat_cyc[1], 1);
    end

    // stride 0: same word repeated
    n_beats = 0;
    send_req(7, 0, 2);
    wait_done();
    check_eq("stride0_beats", n_beats, 3);

`ifdef ITA_RF_RD_HAZARD_EN
    // 5: write to the address about to be read
    n_beats = 0;
    send_req(2, 1, 3);
    for (int i = 0; i < 20 && rf_raddr != AW'(4); i++) tick();
    snoop_we    = 1'b1;
    snoop_waddr = AW'(4);
    snoop_wdata = 32'h55;
    #1;
    check_eq("t5_hold", {31'd0, rf_re}, 32'd0);
    ref_mem[4] = 32'h55;
    tick();
    snoop_we = 1'b0;
    #1;
    check_eq("t5_reissue", {31'd0, rf_re}, 32'd1);
    wait_done();
    check_eq("t5_beats", n_beats, 4);
    snoop_we    = 1'b1;
    snoop_wdata = 32'hA4;
    tick();
    snoop_we   = 1'b0;
    ref_mem[4] = 32'hA4;
`else
    $display("hazard test skipped (ITA_RF_RD_HAZARD_EN not defined)");
`endif

    // 6: asynchronous reset mid-burst
    n_beats = 0;
    send_req(0, 1, 4);
    wait_beats(2);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_eq("t6_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("t6_rf_re", {31'd0, rf_re}, 32'd0);
    check_eq("t6_rf_raddr", {27'd0, rf_raddr}, 32'd0);
    exp_addr.delete();
    exp_last.delete();
    was_stall = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_beats = 0;
    send_req(10, 1, 1);
    wait_done();
    check_eq("t6_after_beats", n_beats, 2);

    // Randomized bursts with random backpressure, sometimes back-to-back
    rand_ready_en = 1;
    n_beats   = 0;
    exp_total = 0;
    for (int b = 0; b < 40; b++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (1 << LW) - 1) : $urandom_range(0, 7);
      send_req($urandom_range(0, NW - 1), $urandom_range(0, NW - 1), len);
      exp_total += len + 1;
      if ($urandom_range(0, 1) == 0) wait_done();
    end
    wait_done();
    rand_ready_en = 0;
    rd_ready = 1'b1;
    check_eq("rand_total_beats", n_beats, exp_total);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
